data_mem_bank_xbar: RTL and testbench
=====================================

# data_mem_bank_xbar

Request crossbar between the core-side OBI data ports and the banked scratchpad data memory. It routes each request to one bank, chosen by word-interleaved address bits. Each bank has its own arbiter across masters. A per-bank FIFO of master IDs returns every bank response to the master that issued it. Per-master outstanding tracking keeps responses in order for each master.

## Interface
- NUM_MASTERS, 4: number of requesting OBI ports; ≥2.
- DATA_MEM_NUM_BANKS, 4: number of banks; power of two, ≥2.
- MAX_OUTSTANDING, 2: maximum unanswered requests per master and per bank; also the per-bank ID FIFO depth; ≥1.
- clk_i  input  1  single clock; all state updates on rising edge.
- rst_ni  input  1  reset, synchronous, active-low.
- core_req  obi_req_if.slave  [NUM_MASTERS]  requests from masters (req, gnt, addr[31:0], we, be[3:0], wdata[31:0]).
- core_rsp  obi_rsp_if.master  [NUM_MASTERS]  responses to masters (rvalid, rdata[31:0]).
- data_mem_req  obi_req_if.master  [DATA_MEM_NUM_BANKS]  requests to banks.
- data_mem_rsp  obi_rsp_if.slave  [DATA_MEM_NUM_BANKS]  responses from banks.

## Operation
- B = log2(DATA_MEM_NUM_BANKS). The target bank is addr[2+B-1:2].
- Bank-local address is {B'b0, addr[31:2+B], addr[1:0]}. we, be and wdata pass through unchanged.
- A master is eligible for bank b when all of the following hold:
  - req=1 and its target is b;
  - its outstanding count < MAX_OUTSTANDING;
  - its outstanding count = 0, or its last-granted bank = b. This bank-lock is what keeps per-master response order.
- Bank b raises data_mem_req[b].req only if at least one master is eligible and FIFO[b] is not full. A simultaneous pop makes a full FIFO count as not full.
- Arbitration: one winner per bank per cycle. The winner's signals drive the bank. The winner's core gnt equals data_mem_req[b].gnt. Losers see gnt=0 and must hold their request stable (OBI rule).
- On a bank handshake (req&gnt):
  - push the winner ID into FIFO[b];
  - increment the winner's outstanding count;
  - set the winner's last bank to b.
- On data_mem_rsp[b].rvalid:
  - pop FIFO[b];
  - drive core_rsp[head].rvalid=1 and rdata=bank rdata;
  - decrement that master's outstanding count.
- Same-cycle grant and response for one master: the count is unchanged.
- Because of the bank-lock, two banks never return to the same master in one cycle.
- rvalid on a bank whose FIFO is empty: the response is dropped and a simulation-only assertion fires.
- Reset while requests are outstanding: FIFOs, counts, last-bank registers and round-robin pointers are all cleared. Bank responses for pre-reset requests that arrive after reset are dropped.

## Timing
- Request path is fully combinational: zero added cycles from core req to bank req, and from bank gnt to core gnt.
- Response path is combinational: core rvalid/rdata appear in the same cycle as bank rvalid.
- End-to-end latency equals bank latency (one cycle for the scratchpad SRAM wrapper).
- Reset values:
  - all core gnt and rvalid = 0;
  - all bank req = 0;
  - rdata = 0;
  - round-robin pointers = 0;
  - outstanding counts = 0;
  - FIFOs empty.
- While rst_ni=0, every req/gnt/rvalid output is forced to 0.
- The round-robin pointer of bank b changes only on a handshake, to (winner+1) mod NUM_MASTERS. It is unchanged in cycles without a handshake.
- The outstanding counter width is clog2(MAX_OUTSTANDING+1). It never wraps; eligibility prevents overflow.

## Configuration
- DATA_MEM_XBAR_RR_EN defined: per-bank round-robin. Search starts at the bank's pointer and goes upward, wrapping at NUM_MASTERS.
- DATA_MEM_XBAR_RR_EN undefined: fixed priority; the lowest master index wins. Pointer registers are not implemented.
- Handshake, FIFO and ordering behaviour are identical in both modes.

## Test plan
- Single master 0 writes addr 0x0000_0014 (bank 1), then reads it back. Required: bank 1 sees addr 0x0000_0004 and the same-cycle gnt; read rdata returns to master 0 one cycle after gnt.
- Masters 0-3 all request bank 2 every cycle (RR_EN defined). Required: grants go 0,1,2,3,0 on consecutive cycles; each master receives exactly its own rdata.
- Same contention with RR_EN undefined. Required: master 0 is always granted while it keeps requesting; master 1 is granted only once master 0 drops req.
- Master 0 has one outstanding request on bank 0 (bank holds rvalid off for 3 cycles) and then requests bank 1. Required: no bank 1 gnt until the bank 0 rvalid; response order is preserved.
- MAX_OUTSTANDING=2, bank 3 stalls rvalid. Required: a third request to bank 3 is not granted until the first rvalid; in the pop cycle the FIFO count stays at 2 and a new grant is issued.
- Assert rst_ni=0 for 1 cycle with 2 requests outstanding. Required: all outputs 0 during reset; late bank rvalid dropped; a fresh request afterwards completes normally.

Source files
------------

// File: rtl/data_mem_bank_xbar.sv
// data_mem_bank_xbar: routes OBI master requests to word-interleaved scratchpad banks and steers
// bank responses back through per-bank master-ID FIFOs. Define DATA_MEM_XBAR_RR_EN for round-robin arbitration.
module data_mem_bank_xbar #(
  parameter int NUM_MASTERS        = 4,
  parameter int DATA_MEM_NUM_BANKS = 4,
  parameter int MAX_OUTSTANDING    = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NUM_MASTERS-1:0]              core_req,
  output logic [NUM_MASTERS-1:0]              core_gnt,
  input  logic [NUM_MASTERS-1:0][31:0]        core_addr,
  input  logic [NUM_MASTERS-1:0]              core_we,
  input  logic [NUM_MASTERS-1:0][3:0]         core_be,
  input  logic [NUM_MASTERS-1:0][31:0]        core_wdata,
  output logic [NUM_MASTERS-1:0]              core_rvalid,
  output logic [NUM_MASTERS-1:0][31:0]        core_rdata,
  output logic [DATA_MEM_NUM_BANKS-1:0]       bank_req,
  input  logic [DATA_MEM_NUM_BANKS-1:0]       bank_gnt,
  output logic [DATA_MEM_NUM_BANKS-1:0][31:0] bank_addr,
  output logic [DATA_MEM_NUM_BANKS-1:0]       bank_we,
  output logic [DATA_MEM_NUM_BANKS-1:0][3:0]  bank_be,
  output logic [DATA_MEM_NUM_BANKS-1:0][31:0] bank_wdata,
  input  logic [DATA_MEM_NUM_BANKS-1:0]       bank_rvalid,
  input  logic [DATA_MEM_NUM_BANKS-1:0][31:0] bank_rdata
);
  localparam int NM = NUM_MASTERS;
  localparam int NB = DATA_MEM_NUM_BANKS;
  localparam int B  = $clog2(NB);
  localparam int MW = $clog2(NM);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [CW-1:0] cnt_reg      [NM];
  logic [B-1:0]  last_reg     [NM];
  logic [MW-1:0] fifo_mem     [NB][MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr_reg   [NB];
  logic [PW-1:0] rd_ptr_reg   [NB];
  logic [CW-1:0] fifo_cnt_reg [NB];

  logic [NB-1:0][NM-1:0] elig;
  logic [NB-1:0][MW-1:0] win;
  logic [NB-1:0][MW-1:0] head;
  logic [NB-1:0]         win_any;
  logic [NB-1:0]         hs;
  logic [NB-1:0]         pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // A busy master is locked to its last bank so its responses cannot overtake each other.
  always_comb begin
    elig = '0;
    for (int b = 0; b < NB; b++) begin
      for (int m = 0; m < NM; m++) begin
        elig[b][m] = core_req[m]
                  && (core_addr[m][2+B-1:2] == B'(b))
                  && (cnt_reg[m] < CW'(MAX_OUTSTANDING))
                  && ((cnt_reg[m] == '0) || (last_reg[m] == B'(b)));
      end
    end
  end

`ifdef DATA_MEM_XBAR_RR_EN
  logic [NB-1:0][MW-1:0] rr_ptr_reg;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr_reg <= '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (hs[b]) rr_ptr_reg[b] <= (win[b] == MW'(NM - 1)) ? '0 : win[b] + 1'b1;
      end
    end
  end

  always_comb begin
    int idx;
    idx     = 0;
    win     = '0;
    win_any = '0;
    for (int b = 0; b < NB; b++) begin
      for (int i = 0; i < NM; i++) begin
        idx = (int'(rr_ptr_reg[b]) + i) % NM;
        if (!win_any[b] && elig[b][idx]) begin
          win_any[b] = 1'b1;
          win[b]     = MW'(idx);
        end
      end
    end
  end
`else
  always_comb begin
    win     = '0;
    win_any = '0;
    for (int b = 0; b < NB; b++) begin
      for (int i = NM - 1; i >= 0; i--) begin
        if (elig[b][i]) begin
          win_any[b] = 1'b1;
          win[b]     = MW'(i);
        end
      end
    end
  end
`endif

  always_comb begin
    bank_req   = '0;
    bank_addr  = '0;
    bank_we    = '0;
    bank_be    = '0;
    bank_wdata = '0;
    hs         = '0;
    pop        = '0;
    head       = '0;
    for (int b = 0; b < NB; b++) begin
      head[b]       = fifo_mem[b][rd_ptr_reg[b]];
      pop[b]        = rst_ni && bank_rvalid[b] && (fifo_cnt_reg[b] != '0);
      // A pop in the same cycle frees the slot the new push needs.
      bank_req[b]   = rst_ni && win_any[b]
                   && ((fifo_cnt_reg[b] != CW'(MAX_OUTSTANDING)) || bank_rvalid[b]);
      bank_addr[b]  = {{B{1'b0}}, core_addr[win[b]][31:2+B], core_addr[win[b]][1:0]};
      bank_we[b]    = core_we[win[b]];
      bank_be[b]    = core_be[win[b]];
      bank_wdata[b] = core_wdata[win[b]];
      hs[b]         = bank_req[b] && bank_gnt[b];
    end
  end

  always_comb begin
    core_gnt    = '0;
    core_rvalid = '0;
    core_rdata  = '0;
    for (int b = 0; b < NB; b++) begin
      if (hs[b]) core_gnt[win[b]] = 1'b1;
      if (pop[b]) begin
        core_rvalid[head[b]] = 1'b1;
        core_rdata[head[b]]  = bank_rdata[b];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int m = 0; m < NM; m++) begin
        cnt_reg[m]  <= '0;
        last_reg[m] <= '0;
      end
      for (int b = 0; b < NB; b++) begin
        wr_ptr_reg[b]   <= '0;
        rd_ptr_reg[b]   <= '0;
        fifo_cnt_reg[b] <= '0;
      end
    end else begin
      for (int m = 0; m < NM; m++) begin
        cnt_reg[m] <= cnt_reg[m] + CW'(core_gnt[m]) - CW'(core_rvalid[m]);
      end
      for (int b = 0; b < NB; b++) begin
        if (hs[b]) begin
          last_reg[win[b]] <= B'(b);
          wr_ptr_reg[b]    <= next_ptr(wr_ptr_reg[b]);
        end
        if (pop[b]) rd_ptr_reg[b] <= next_ptr(rd_ptr_reg[b]);
        fifo_cnt_reg[b] <= fifo_cnt_reg[b] + CW'(hs[b]) - CW'(pop[b]);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NB; b++) begin
      if (hs[b]) fifo_mem[b][wr_ptr_reg[b]] <= win[b];
    end
  end

`ifndef SYNTHESIS
  // Late answers to requests issued before a reset are legal and dropped until traffic resumes.
  logic stale_window_reg;

  always_ff @(posedge clk_i) begin
    if (!rst_ni)  stale_window_reg <= 1'b1;
    else if (|hs) stale_window_reg <= 1'b0;
  end

  for (genvar gi = 0; gi < NB; gi++) begin : g_orphan_chk
    always_ff @(posedge clk_i) begin
      if (rst_ni && !stale_window_reg) begin
        assert (!(bank_rvalid[gi] && (fifo_cnt_reg[gi] == '0)))
          else $error("bank %0d: rvalid with empty ID FIFO", gi);
      end
    end
  end
`endif
endmodule

// File: tb/tb_data_mem_bank_xbar.sv
// Directed bench for data_mem_bank_xbar: routing, arbitration, bank lock, FIFO-full bypass, reset.
module tb_data_mem_bank_xbar;
  localparam int NM = 4;
  localparam int NB = 4;

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b0;
  logic [NM-1:0]        core_req;
  logic [NM-1:0]        core_gnt;
  logic [NM-1:0][31:0]  core_addr;
  logic [NM-1:0]        core_we;
  logic [NM-1:0][3:0]   core_be;
  logic [NM-1:0][31:0]  core_wdata;
  logic [NM-1:0]        core_rvalid;
  logic [NM-1:0][31:0]  core_rdata;
  logic [NB-1:0]        bank_req;
  logic [NB-1:0]        bank_gnt;
  logic [NB-1:0][31:0]  bank_addr;
  logic [NB-1:0]        bank_we;
  logic [NB-1:0][3:0]   bank_be;
  logic [NB-1:0][31:0]  bank_wdata;
  logic [NB-1:0]        bank_rvalid;
  logic [NB-1:0][31:0]  bank_rdata;

  data_mem_bank_xbar #(
    .NUM_MASTERS       (NM),
    .DATA_MEM_NUM_BANKS(NB),
    .MAX_OUTSTANDING   (2)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .core_req   (core_req),
    .core_gnt   (core_gnt),
    .core_addr  (core_addr),
    .core_we    (core_we),
    .core_be    (core_be),
    .core_wdata (core_wdata),
    .core_rvalid(core_rvalid),
    .core_rdata (core_rdata),
    .bank_req   (bank_req),
    .bank_gnt   (bank_gnt),
    .bank_addr  (bank_addr),
    .bank_we    (bank_we),
    .bank_be    (bank_be),
    .bank_wdata (bank_wdata),
    .bank_rvalid(bank_rvalid),
    .bank_rdata (bank_rdata)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [3:0]  req;
    logic [7:0]  tgt;     // two bits of target bank per master
    logic [3:0]  gnt;
    logic [3:0]  rv;
    logic [31:0] rd;
    logic [3:0]  e_breq;
    logic [3:0]  e_cgnt;
    logic [3:0]  e_crv;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  int checks   = 0;
  int failures = 0;
  int exp_w;
  int prev_w;

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Master m addresses word m of its target bank.
  task automatic drive(input logic [3:0] req, input logic [7:0] tgt, input logic [3:0] gnt,
                       input logic [3:0] rv, input logic [31:0] rd);
    for (int m = 0; m < NM; m++) begin
      core_req[m]   = req[m];
      core_addr[m]  = {24'h0, 4'(m), tgt[2*m +: 2], 2'b00};
      core_we[m]    = 1'b0;
      core_be[m]    = 4'hF;
      core_wdata[m] = 32'hC0DE_0000 | 32'(m);
    end
    bank_gnt    = gnt;
    bank_rvalid = rv;
    for (int b = 0; b < NB; b++) bank_rdata[b] = rd;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //            req      tgt    gnt    rv       rd            e_breq   e_cgnt   e_crv
    vecs[0]  = '{4'b0001, 8'h00, 4'hF, 4'b0000, 32'h0,        4'b0001, 4'b0001, 4'b0000};
    vecs[1]  = '{4'b0001, 8'h01, 4'hF, 4'b0000, 32'h0,        4'b0000, 4'b0000, 4'b0000};
    vecs[2]  = '{4'b0001, 8'h01, 4'hF, 4'b0000, 32'h0,        4'b0000, 4'b0000, 4'b0000};
    vecs[3]  = '{4'b0001, 8'h01, 4'hF, 4'b0001, 32'hB000_0000, 4'b0000, 4'b0000, 4'b0001};
    vecs[4]  = '{4'b0001, 8'h01, 4'hF, 4'b0000, 32'h0,        4'b0010, 4'b0001, 4'b0000};
    vecs[5]  = '{4'b0000, 8'h01, 4'hF, 4'b0010, 32'hB000_0001, 4'b0000, 4'b0000, 4'b0001};
    vecs[6]  = '{4'b0100, 8'h30, 4'hF, 4'b0000, 32'h0,        4'b1000, 4'b0100, 4'b0000};
    vecs[7]  = '{4'b0100, 8'h30, 4'hF, 4'b0000, 32'h0,        4'b1000, 4'b0100, 4'b0000};
    vecs[8]  = '{4'b1100, 8'hF0, 4'hF, 4'b0000, 32'h0,        4'b0000, 4'b0000, 4'b0000};
    vecs[9]  = '{4'b1100, 8'hF0, 4'hF, 4'b1000, 32'hC000_0000, 4'b1000, 4'b1000, 4'b0100};
    vecs[10] = '{4'b1100, 8'hF0, 4'hF, 4'b0000, 32'h0,        4'b0000, 4'b0000, 4'b0000};
    vecs[11] = '{4'b1100, 8'hF0, 4'hF, 4'b1000, 32'hC000_0001, 4'b1000, 4'b0100, 4'b0100};
    vecs[12] = '{4'b0000, 8'hF0, 4'hF, 4'b1000, 32'hC000_0002, 4'b0000, 4'b0000, 4'b1000};
    vecs[13] = '{4'b0000, 8'hF0, 4'hF, 4'b1000, 32'hC000_0003, 4'b0000, 4'b0000, 4'b0100};
    vecs[14] = '{4'b0001, 8'h00, 4'h0, 4'b0000, 32'h0,        4'b0001, 4'b0000, 4'b0000};
    vecs[15] = '{4'b0001, 8'h00, 4'hF, 4'b0000, 32'h0,        4'b0001, 4'b0001, 4'b0000};
    vecs[16] = '{4'b0000, 8'h00, 4'hF, 4'b0001, 32'hD000_0000, 4'b0000, 4'b0000, 4'b0001};

    // Reset with every input active: all handshake outputs must stay low.
    drive(4'hF, 8'hE4, 4'hF, 4'hF, 32'hFFFF_FFFF);
    rst_ni = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      chk4("reset_core_gnt", core_gnt, 4'b0000);
      chk4("reset_bank_req", bank_req, 4'b0000);
      chk4("reset_core_rvalid", core_rvalid, 4'b0000);
      chk32("reset_core_rdata0", core_rdata[0], 32'h0);
      step();
    end
    rst_ni = 1'b1;

    // Master 0 writes 0x14 (bank 1, local 0x4) and reads it back.
    drive(4'b0000, 8'h00, 4'hF, 4'b0000, 32'h0);
    core_req[0] = 1'b1; core_we[0] = 1'b1; core_addr[0] = 32'h0000_0014; core_wdata[0] = 32'h1234_5678;
    @(negedge clk_i);
    chk4("wr_bank_req", bank_req, 4'b0010);
    chk32("wr_bank_addr", bank_addr[1], 32'h0000_0004);
    chk4("wr_bank_we", {3'b000, bank_we[1]}, 4'b0001);
    chk32("wr_bank_wdata", bank_wdata[1], 32'h1234_5678);
    chk4("wr_core_gnt", core_gnt, 4'b0001);
    step();
    drive(4'b0000, 8'h00, 4'hF, 4'b0010, 32'h0);
    @(negedge clk_i);
    chk4("wr_core_rvalid", core_rvalid, 4'b0001);
    step();
    drive(4'b0000, 8'h00, 4'hF, 4'b0000, 32'h0);
    core_req[0] = 1'b1; core_addr[0] = 32'h0000_0014;
    @(negedge clk_i);
    chk32("rd_bank_addr", bank_addr[1], 32'h0000_0004);
    chk4("rd_bank_we", {3'b000, bank_we[1]}, 4'b0000);
    chk4("rd_core_gnt", core_gnt, 4'b0001);
    step();
    drive(4'b0000, 8'h00, 4'hF, 4'b0010, 32'h1234_5678);
    @(negedge clk_i);
    chk4("rd_core_rvalid", core_rvalid, 4'b0001);
    chk32("rd_core_rdata0", core_rdata[0], 32'h1234_5678);
    step();

    // All masters hammer bank 2; the bank answers each grant one cycle later.
    prev_w = 0;
    for (int k = 0; k < 5; k++) begin
      drive(4'hF, 8'hAA, 4'hF, (k > 0) ? 4'b0100 : 4'b0000, 32'hA000_0000 + 32'(k));
`ifdef DATA_MEM_XBAR_RR_EN
      exp_w = k % NM;
`else
      exp_w = 0;
`endif
      @(negedge clk_i);
      chk4($sformatf("cont%0d_gnt", k), core_gnt, 4'(1 << exp_w));
      chk4($sformatf("cont%0d_rvalid", k), core_rvalid, (k > 0) ? 4'(1 << prev_w) : 4'b0000);
      if (k > 0) chk32($sformatf("cont%0d_rdata", k), core_rdata[prev_w], 32'hA000_0000 + 32'(k));
      prev_w = exp_w;
      step();
    end
    drive(4'b1110, 8'hAA, 4'hF, 4'b0100, 32'hA000_0005);
    @(negedge clk_i);
    chk4("cont_drop0_gnt", core_gnt, 4'b0010);
    chk4("cont_drop0_rvalid", core_rvalid, 4'b0001);
    chk32("cont_drop0_rdata", core_rdata[0], 32'hA000_0005);
    step();
    drive(4'b0000, 8'hAA, 4'hF, 4'b0100, 32'hA000_0006);
    @(negedge clk_i);
    chk4("cont_tail_gnt", core_gnt, 4'b0000);
    chk4("cont_tail_rvalid", core_rvalid, 4'b0010);
    chk32("cont_tail_rdata", core_rdata[1], 32'hA000_0006);
    step();

    // Bank lock, outstanding limit, FIFO-full bypass on pop, bank gnt stall.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].req, vecs[i].tgt, vecs[i].gnt, vecs[i].rv, vecs[i].rd);
      @(negedge clk_i);
      chk4($sformatf("vec%0d_bank_req", i), bank_req, vecs[i].e_breq);
      chk4($sformatf("vec%0d_core_gnt", i), core_gnt, vecs[i].e_cgnt);
      chk4($sformatf("vec%0d_core_rvalid", i), core_rvalid, vecs[i].e_crv);
      for (int m = 0; m < NM; m++) begin
        if (vecs[i].e_crv[m]) chk32($sformatf("vec%0d_core_rdata%0d", i, m), core_rdata[m], vecs[i].rd);
      end
      step();
    end

    // Reset with two requests outstanding; their late responses must vanish.
    drive(4'b0011, 8'h04, 4'hF, 4'b0000, 32'h0);
    @(negedge clk_i);
    chk4("rst_pre_gnt", core_gnt, 4'b0011);
    chk4("rst_pre_bank_req", bank_req, 4'b0011);
    step();
    rst_ni = 1'b0;
    drive(4'b0011, 8'h04, 4'hF, 4'b0011, 32'hE000_0000);
    @(negedge clk_i);
    chk4("rst_mid_gnt", core_gnt, 4'b0000);
    chk4("rst_mid_bank_req", bank_req, 4'b0000);
    chk4("rst_mid_rvalid", core_rvalid, 4'b0000);
    chk32("rst_mid_rdata0", core_rdata[0], 32'h0);
    chk32("rst_mid_rdata1", core_rdata[1], 32'h0);
    step();
    rst_ni = 1'b1;
    drive(4'b0000, 8'h04, 4'hF, 4'b0011, 32'hE000_0001);
    @(negedge clk_i);
    chk4("rst_late_rvalid", core_rvalid, 4'b0000);
    step();
    drive(4'b0010, 8'h0C, 4'hF, 4'b0000, 32'h0);
    @(negedge clk_i);
    chk4("rst_fresh_bank_req", bank_req, 4'b1000);
    chk4("rst_fresh_gnt", core_gnt, 4'b0010);
    chk32("rst_fresh_bank_addr", bank_addr[3], 32'h0000_0004);
    step();
    drive(4'b0000, 8'h0C, 4'hF, 4'b1000, 32'hE000_0002);
    @(negedge clk_i);
    chk4("rst_fresh_rvalid", core_rvalid, 4'b0010);
    chk32("rst_fresh_rdata1", core_rdata[1], 32'hE000_0002);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
